// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared widths, reset PC, fetch FSM states and PC increment
package pc_fetch_unit_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: sequential PC+4 or branch target (br_pc + br_imm, low bits cleared)
//   pc, br_pc, br_imm : current PC, redirecting PC, sign-extended offset
//   sel               : 1 selects the branch target
//   tgt               : branch target, always produced
//   nxt               : selected next PC
module next_pc_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            sel,
    output logic [XLEN-1:0] tgt,
    output logic [XLEN-1:0] nxt
);
    logic [XLEN-1:0] sum;
    assign sum = br_pc + br_imm;
    assign tgt = sum & ~XLEN'(3);
    assign nxt = sel ? tgt : pc + XLEN'(PC_STEP);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, single-outstanding instruction fetch, decode handoff
//   clk, rst_n                  : clock, asynchronous active-low reset
//   br_taken, br_pc, br_imm     : redirect pulse and its target operands
//   imem_req/addr/ack/rdata     : instruction memory read port
//   dec_valid/ready/instr/pc    : valid/ready handoff to decode
//   flush_cnt                   : saturating count of discarded fetches
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [15:0]     flush_cnt
);
    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n, pend_tgt, pend_n, instr_n, dpc_n, tgt, nxt;
    logic            flush_pend, fp_n, gap, gap_n, valid_n, flush_inc;

    next_pc_sel #(.XLEN(XLEN)) u_sel (
        .pc    (pc),
        .br_pc (br_pc),
        .br_imm(br_imm),
        .sel   (br_taken),
        .tgt   (tgt),
        .nxt   (nxt)
    );

    // gap holds the request low for the one cycle after a discarded response
    assign imem_req  = (state == REQ) && !gap;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_tgt   <= '0;
            flush_pend <= 1'b0;
            gap        <= 1'b0;
            dec_valid  <= 1'b0;
            dec_instr  <= '0;
            dec_pc     <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_tgt   <= pend_n;
            flush_pend <= fp_n;
            gap        <= gap_n;
            dec_valid  <= valid_n;
            dec_instr  <= instr_n;
            dec_pc     <= dpc_n;
            flush_cnt  <= flush_cnt + 16'((flush_inc && flush_cnt != 16'hFFFF) ? 1 : 0);
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pend_n    = pend_tgt;
        fp_n      = flush_pend;
        gap_n     = 1'b0;
        valid_n   = dec_valid;
        instr_n   = dec_instr;
        dpc_n     = dec_pc;
        flush_inc = 1'b0;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (gap) begin
                    // nothing outstanding, so a redirect simply retargets the PC
                    pc_n = br_taken ? tgt : pc;
                end else if (imem_ack) begin
                    if (flush_pend || br_taken) begin
                        flush_inc = 1'b1;
                        pc_n      = br_taken ? tgt : pend_tgt;
                        fp_n      = 1'b0;
                        gap_n     = 1'b1;
                    end else begin
                        instr_n = imem_rdata;
                        dpc_n   = pc;
                        valid_n = 1'b1;
                        pc_n    = nxt;
                        state_n = HOLD;
                    end
                end else if (br_taken) begin
                    // address must stay put until ack; remember the latest target
                    pend_n = tgt;
                    fp_n   = 1'b1;
                end
            end
            HOLD: begin
                if (br_taken || dec_ready) begin
                    valid_n   = 1'b0;
                    state_n   = REQ;
                    pc_n      = br_taken ? nxt : pc;
                    flush_inc = br_taken && !dec_ready;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
